// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction fetch with IF/ID register; optional counters via `ifdef FETCH_STATS_EN.
// Latency: the word at PC appears on instr_d one cycle after PC is presented on imem_addr.
// Backpressure: stall_d holds PC and IF/ID; PCSrc redirect overrides stall and injects a bubble.
module fetch_stage #(
    parameter int            N        = 64,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_data,
    input  logic         stall_d,
    input  logic         PCSrc,
    input  logic [N-1:0] PCBranch,
    output logic [31:0]  instr_d,
    output logic [10:0]  op_d,
    output logic [N-1:0] pc_d,
    output logic         valid_d,
    output logic [31:0]  fetched_cnt,
    output logic [31:0]  squash_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_pc;
    logic [31:0]    r_instr;
    logic [N-1:0]   r_pc_d;
    logic           r_valid;

    logic           w_active;
    logic           w_redirect;
    logic           w_load;
    logic [N-1:0]   w_target;
    logic [N-1:0]   w_pc_inc;

    // BOOT spends one cycle idle so the first fetch at RESET_PC happens in RUN;
    // redirects are ignored there. HOLD exiting with stall_d=0 loads immediately
    // so the held instruction is never presented to decode twice.
    assign w_active   = (r_state != ST_BOOT);
    assign w_redirect = w_active && PCSrc;
    assign w_load     = w_active && !PCSrc && !stall_d;
    assign w_target   = {PCBranch[N-1:2], 2'b00};
    assign w_pc_inc   = r_pc + N'(4);

    // Fetch FSM: PC, IF/ID register and state, redirect taking priority over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_pc_d  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  r_state <= (stall_d && !PCSrc) ? ST_HOLD : ST_RUN;
                ST_HOLD: r_state <= (!stall_d || PCSrc) ? ST_RUN : ST_HOLD;
                default: r_state <= ST_BOOT;
            endcase

            if (w_redirect) begin
                r_pc    <= w_target;
                r_instr <= 32'h0;
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_pc    <= w_pc_inc;
                r_instr <= imem_data;
                r_pc_d  <= r_pc;
                r_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetched_cnt;
    logic [31:0] r_squash_cnt;

    // Event counters: valid IF/ID loads and accepted redirects, free-running wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetched_cnt <= 32'h0;
            r_squash_cnt  <= 32'h0;
        end else begin
            if (w_load)
                r_fetched_cnt <= r_fetched_cnt + 32'd1;
            if (w_redirect)
                r_squash_cnt  <= r_squash_cnt + 32'd1;
        end
    end

    assign fetched_cnt = r_fetched_cnt;
    assign squash_cnt  = r_squash_cnt;
`else
    assign fetched_cnt = 32'h0;
    assign squash_cnt  = 32'h0;
`endif

    assign imem_addr = r_pc;
    assign instr_d   = r_instr;
    assign op_d      = r_instr[31:21];
    assign pc_d      = r_pc_d;
    assign valid_d   = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a fetch scoreboard.
// Latency: one cycle per step, outputs sampled 1ns after the rising edge.
// Backpressure: stall and redirect driven directly; a second instance checks PC wrap.
module tb_fetch_stage;

    localparam int N = 64;
    localparam logic [N-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0]  WRAP_WORD = 32'hAA55_1234;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] imem_addr;
    logic [31:0]  imem_data;
    logic         stall_d;
    logic         PCSrc;
    logic [N-1:0] PCBranch;
    logic [31:0]  instr_d;
    logic [10:0]  op_d;
    logic [N-1:0] pc_d;
    logic         valid_d;
    logic [31:0]  fetched_cnt;
    logic [31:0]  squash_cnt;

    logic [N-1:0] w_imem_addr;
    logic [31:0]  w_instr_d;
    logic [10:0]  w_op_d;
    logic [N-1:0] w_pc_d;
    logic         w_valid_d;
    logic [31:0]  w_fetched_cnt;
    logic [31:0]  w_squash_cnt;

    logic [31:0]  mem [0:127];

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]  instr;
        logic [N-1:0] pc;
    } fetch_t;
    fetch_t sb_q[$];

    always #5 clk = ~clk;

    assign imem_data = (imem_addr[N-1:9] == '0) ? mem[imem_addr[8:2]] : 32'hD503_201F;

    fetch_stage #(.N(N), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall_d(stall_d), .PCSrc(PCSrc), .PCBranch(PCBranch),
        .instr_d(instr_d), .op_d(op_d), .pc_d(pc_d), .valid_d(valid_d),
        .fetched_cnt(fetched_cnt), .squash_cnt(squash_cnt)
    );

    fetch_stage #(.N(N), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_data(WRAP_WORD),
        .stall_d(1'b0), .PCSrc(1'b0), .PCBranch(64'h0),
        .instr_d(w_instr_d), .op_d(w_op_d), .pc_d(w_pc_d), .valid_d(w_valid_d),
        .fetched_cnt(w_fetched_cnt), .squash_cnt(w_squash_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [N-1:0] addr);
        fetch_t f;
        f.instr = mem[addr[8:2]];
        f.pc    = addr;
        sb_q.push_back(f);
    endtask

    // One cycle in which the DUT is expected to load IF/ID; compare against the scoreboard head.
    task automatic fetch_step(input string tag);
        fetch_t f;
        step();
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            f = sb_q.pop_front();
            chk({tag, "_valid"}, 64'(valid_d), 64'd1);
            chk({tag, "_instr"}, 64'(instr_d), 64'(f.instr));
            chk({tag, "_op"},    64'(op_d),    64'(f.instr[31:21]));
            chk({tag, "_pc"},    pc_d,         f.pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h9100_0000 | i;
        mem[0] = 32'hF840_0000;
        mem[1] = 32'h8B00_0000;

        reset    = 1'b1;
        stall_d  = 1'b0;
        PCSrc    = 1'b0;
        PCBranch = '0;
        step();
        step();

        chk("rst_valid",   64'(valid_d),     64'd0);
        chk("rst_instr",   64'(instr_d),     64'd0);
        chk("rst_pc_d",    pc_d,             64'd0);
        chk("rst_addr",    imem_addr,        64'd0);
        chk("rst_fcnt",    64'(fetched_cnt), 64'd0);
        chk("rst_scnt",    64'(squash_cnt),  64'd0);
        chk("rst_wrap_pc", w_imem_addr,      WRAP_PC);

        // BOOT cycle: a redirect here must be ignored.
        reset    = 1'b0;
        PCSrc    = 1'b1;
        PCBranch = 64'h40;
        step();
        chk("boot_valid", 64'(valid_d), 64'd0);
        chk("boot_addr",  imem_addr,    64'd0);
        chk("boot_wrap",  w_imem_addr,  WRAP_PC);
        PCSrc = 1'b0;

        // Two-instruction stream from address 0.
        push_fetch(64'h0);
        fetch_step("f0");
        chk("f0_op_lit", 64'(op_d), 64'h7C2);
        chk("wrap_pc",    w_imem_addr,     64'd0);
        chk("wrap_pc_d",  w_pc_d,          WRAP_PC);
        chk("wrap_valid", 64'(w_valid_d),  64'd1);
        chk("wrap_instr", 64'(w_instr_d),  64'(WRAP_WORD));
        push_fetch(64'h4);
        fetch_step("f1");
        chk("f1_op_lit", 64'(op_d), 64'h458);
        chk("f1_addr",   imem_addr, 64'h8);

        // Decode stall for three cycles: everything frozen at PC=8.
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr",  imem_addr,    64'h8);
            chk("stall_valid", 64'(valid_d), 64'd1);
            chk("stall_instr", 64'(instr_d), 64'h8B00_0000);
            chk("stall_pc_d",  pc_d,         64'h4);
        end

        // Redirect while stalled: wins over stall, low bits dropped, bubble out.
        PCSrc    = 1'b1;
        PCBranch = 64'h103;
        step();
        chk("redir_valid", 64'(valid_d), 64'd0);
        chk("redir_instr", 64'(instr_d), 64'd0);
        chk("redir_op",    64'(op_d),    64'd0);
        chk("redir_addr",  imem_addr,    64'h100);

        PCSrc   = 1'b0;
        stall_d = 1'b0;
        push_fetch(64'h100);
        fetch_step("f2");
        push_fetch(64'h104);
        fetch_step("f3");
        push_fetch(64'h108);
        fetch_step("f4");
        chk("f4_addr", imem_addr, 64'h10C);

`ifdef FETCH_STATS_EN
        chk("cnt_fetched", 64'(fetched_cnt), 64'd5);
        chk("cnt_squash",  64'(squash_cnt),  64'd1);
`else
        chk("cnt_fetched", 64'(fetched_cnt), 64'd0);
        chk("cnt_squash",  64'(squash_cnt),  64'd0);
`endif

        // Redirect in RUN without stall, then resume at the target.
        PCSrc    = 1'b1;
        PCBranch = 64'h20;
        step();
        chk("run_redir_valid", 64'(valid_d), 64'd0);
        chk("run_redir_addr",  imem_addr,    64'h20);
        PCSrc = 1'b0;
        push_fetch(64'h20);
        fetch_step("f5");

        // Reset mid-operation with a redirect pending: reset wins.
        reset    = 1'b1;
        PCSrc    = 1'b1;
        PCBranch = 64'h80;
        step();
        chk("mid_rst_addr",  imem_addr,    64'd0);
        chk("mid_rst_valid", 64'(valid_d), 64'd0);
        chk("mid_rst_fcnt",  64'(fetched_cnt), 64'd0);
        reset = 1'b0;
        PCSrc = 1'b0;

        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
